// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: data-memory access over req/ack, branch resolve, MEM/WB register
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [1:0]  WB_IN,
    input  logic [2:0]  MEM_IN,
    input  logic [31:0] BranchPC_IN,
    input  logic [31:0] AluResult_IN,
    input  logic [31:0] RD2_IN,
    input  logic        Zero_IN,
    input  logic [4:0]  WR_IN,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_WData,
    input  logic [31:0] Mem_RData,
    input  logic        Mem_Ack,
    output logic        Stall,
    output logic        PCSrc,
    output logic [31:0] BranchPC_OUT,
    output logic [1:0]  WB_OUT,
    output logic [31:0] ReadData_OUT,
    output logic [31:0] AluResult_OUT,
    output logic [4:0]  WR_OUT,
    output logic        Misalign,
    output logic        Bus_Err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              memop, aligned, issue, timeout;

    assign memop   = MEM_IN[1] | MEM_IN[0];
    assign aligned = (AluResult_IN[1:0] == 2'b00);
    assign issue   = (state == IDLE) && memop && aligned;
    assign timeout = (state == ACCESS) && !Mem_Ack && (cnt == CNT_W'(TIMEOUT - 1));

    // Gated by reset so the earlier stages are released while the stage is held in reset.
    assign Stall        = Rst_n && (issue || ((state == ACCESS) && !Mem_Ack));
    assign PCSrc        = MEM_IN[2] && Zero_IN && (state == IDLE);
    assign BranchPC_OUT = BranchPC_IN;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = ACCESS;
            ACCESS:  if (Mem_Ack || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (issue)
                cnt <= '0;
            else if ((state == ACCESS) && !Mem_Ack && !timeout)
                cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Mem_Req       <= 1'b0;
            Mem_We        <= 1'b0;
            Mem_Addr      <= '0;
            Mem_WData     <= '0;
            WB_OUT        <= '0;
            ReadData_OUT  <= '0;
            AluResult_OUT <= '0;
            WR_OUT        <= '0;
            Misalign      <= 1'b0;
            Bus_Err       <= 1'b0;
        end else if (state == IDLE) begin
            if (issue) begin
                Mem_Req   <= 1'b1;
                Mem_We    <= MEM_IN[0];
                Mem_Addr  <= AluResult_IN;
                Mem_WData <= RD2_IN;
                WB_OUT    <= '0;
            end else if (memop) begin
                Misalign <= 1'b1;
                WB_OUT   <= '0;
            end else begin
                WB_OUT        <= WB_IN;
                AluResult_OUT <= AluResult_IN;
                WR_OUT        <= WR_IN;
                ReadData_OUT  <= '0;
            end
        end else if (Mem_Ack) begin
            // Inputs are held by Stall during the access, so they still describe this instruction.
            Mem_Req       <= 1'b0;
            WB_OUT        <= WB_IN;
            AluResult_OUT <= AluResult_IN;
            WR_OUT        <= WR_IN;
            ReadData_OUT  <= Mem_We ? 32'd0 : Mem_RData;
        end else if (timeout) begin
            Mem_Req <= 1'b0;
            Bus_Err <= 1'b1;
            WB_OUT  <= '0;
        end else begin
            WB_OUT <= '0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [1:0]  WB_IN;
    logic [2:0]  MEM_IN;
    logic [31:0] BranchPC_IN, AluResult_IN, RD2_IN;
    logic        Zero_IN;
    logic [4:0]  WR_IN;
    logic        Mem_Req, Mem_We;
    logic [31:0] Mem_Addr, Mem_WData, Mem_RData;
    logic        Mem_Ack;
    logic        Stall, PCSrc;
    logic [31:0] BranchPC_OUT;
    logic [1:0]  WB_OUT;
    logic [31:0] ReadData_OUT, AluResult_OUT;
    logic [4:0]  WR_OUT;
    logic        Misalign, Bus_Err;

    always #5 Clk = ~Clk;

    mem_access_stage #(.TIMEOUT(4), .CNT_W(5)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .WB_IN(WB_IN), .MEM_IN(MEM_IN),
        .BranchPC_IN(BranchPC_IN), .AluResult_IN(AluResult_IN), .RD2_IN(RD2_IN),
        .Zero_IN(Zero_IN), .WR_IN(WR_IN), .Mem_Req(Mem_Req), .Mem_We(Mem_We),
        .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData), .Mem_RData(Mem_RData),
        .Mem_Ack(Mem_Ack), .Stall(Stall), .PCSrc(PCSrc), .BranchPC_OUT(BranchPC_OUT),
        .WB_OUT(WB_OUT), .ReadData_OUT(ReadData_OUT), .AluResult_OUT(AluResult_OUT),
        .WR_OUT(WR_OUT), .Misalign(Misalign), .Bus_Err(Bus_Err)
    );

    typedef struct {
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  wr;
        logic        zero;
        logic [31:0] bpc;
        int          ack_dly;
        logic [31:0] rdata;
        logic [31:0] exp_rd;
        int          exp_stall;
        logic        exp_pcsrc;
        logic        exp_we;
    } vec_t;

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [31:0] rd;
    } mw_t;

    mw_t  sb[$];
    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] wb, input logic [2:0] mem, input logic [31:0] alu,
                         input logic [31:0] rd2, input logic [4:0] wr, input logic zero,
                         input logic [31:0] bpc);
        WB_IN = wb; MEM_IN = mem; AluResult_IN = alu; RD2_IN = rd2;
        WR_IN = wr; Zero_IN = zero; BranchPC_IN = bpc;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int  stalls = 0;
        int  reqs = 0;
        bit  done = 0;
        bit  bus_bad = 0;
        bit  bub_bad = 0;
        mw_t e;
        drive(v.wb, v.mem, v.alu, v.rd2, v.wr, v.zero, v.bpc);
        Mem_Ack = 1'b0;
        #1;
        chk({tag, "_pcsrc"}, {31'd0, PCSrc}, {31'd0, v.exp_pcsrc});
        chk({tag, "_bpc"}, BranchPC_OUT, v.bpc);
        e.wb = v.wb; e.alu = v.alu; e.wr = v.wr; e.rd = v.exp_rd;
        sb.push_back(e);
        for (int i = 0; i < 40 && !done; i++) begin
            if (i > 0 && WB_OUT !== 2'b00) bub_bad = 1;
            if (Mem_Req) begin
                reqs++;
                if (Mem_Addr !== v.alu || Mem_We !== v.exp_we || Mem_WData !== v.rd2) bus_bad = 1;
                Mem_Ack   = (reqs == v.ack_dly);
                Mem_RData = Mem_Ack ? v.rdata : $urandom;
            end else begin
                Mem_Ack = 1'b0;
            end
            #1;
            if (Stall) stalls++;
            else done = 1;
            tick();
        end
        Mem_Ack = 1'b0;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_stall_cycles"}, stalls, v.exp_stall);
        chk({tag, "_req_cycles"}, reqs, v.ack_dly);
        chk({tag, "_bus_stable"}, {31'd0, bus_bad}, 32'd0);
        chk({tag, "_bubble"}, {31'd0, bub_bad}, 32'd0);
        e = sb.pop_front();
        chk({tag, "_wb_out"}, {30'd0, WB_OUT}, {30'd0, e.wb});
        chk({tag, "_alu_out"}, AluResult_OUT, e.alu);
        chk({tag, "_wr_out"}, {27'd0, WR_OUT}, {27'd0, e.wr});
        chk({tag, "_rdata_out"}, ReadData_OUT, e.rd);
    endtask

    initial begin
        int reqs;
        bit stall_bad;

        //            wb     mem     alu           rd2           wr     z     bpc    ack rdata         exp_rd        st pc we
        vecs[0] = '{2'b10, 3'b000, 32'hFFFFFFCE, 32'd0,       5'd7,  1'b0, 32'd0, 0, 32'd0,        32'd0,        0, 0, 0};
        vecs[1] = '{2'b11, 3'b010, 32'h40,       32'd0,       5'd3,  1'b0, 32'd0, 4, 32'hDEADBEEF, 32'hDEADBEEF, 4, 0, 0};
        vecs[2] = '{2'b00, 3'b001, 32'h8,        32'd5,       5'd0,  1'b0, 32'd0, 1, 32'h11111111, 32'd0,        1, 0, 1};
        vecs[3] = '{2'b00, 3'b100, 32'h0,        32'd0,       5'd0,  1'b1, 32'd5, 0, 32'd0,        32'd0,        0, 1, 0};
        vecs[4] = '{2'b00, 3'b100, 32'h4,        32'd0,       5'd0,  1'b0, 32'd5, 0, 32'd0,        32'd0,        0, 0, 0};
        vecs[5] = '{2'b01, 3'b011, 32'h10,       32'h1234,    5'd9,  1'b0, 32'd0, 2, 32'h77777777, 32'd0,        2, 0, 1};
        vecs[6] = '{2'b01, 3'b010, 32'h100,      32'd0,       5'd31, 1'b0, 32'd0, 1, 32'hCAFEF00D, 32'hCAFEF00D, 1, 0, 0};

        Rst_n = 1'b0; Mem_Ack = 1'b0; Mem_RData = '0;
        drive(2'b00, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        tick();
        chk("rst_req", {31'd0, Mem_Req}, 32'd0);
        chk("rst_wb", {30'd0, WB_OUT}, 32'd0);
        chk("rst_alu", AluResult_OUT, 32'd0);
        chk("rst_flags", {30'd0, Misalign, Bus_Err}, 32'd0);
        Rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // misaligned load: no bus, no stall, bubble, sticky flag
        drive(2'b11, 3'b010, 32'h41, 32'd0, 5'd2, 1'b0, 32'd0);
        #1;
        chk("mis_stall", {31'd0, Stall}, 32'd0);
        tick();
        chk("mis_flag", {31'd0, Misalign}, 32'd1);
        chk("mis_req", {31'd0, Mem_Req}, 32'd0);
        chk("mis_wb", {30'd0, WB_OUT}, 32'd0);

        // timeout: 4 ACCESS cycles, abort, retry, then complete
        drive(2'b11, 3'b010, 32'h20, 32'd0, 5'd4, 1'b0, 32'd0);
        Mem_Ack = 1'b0;
        tick();
        reqs = 0; stall_bad = 0;
        for (int i = 0; i < 20 && Mem_Req; i++) begin
            reqs++;
            if (!Stall) stall_bad = 1;
            tick();
        end
        chk("to_req_cycles", reqs, 4);
        chk("to_stall_held", {31'd0, stall_bad}, 32'd0);
        chk("to_bus_err", {31'd0, Bus_Err}, 32'd1);
        chk("to_wb_bubble", {30'd0, WB_OUT}, 32'd0);
        chk("to_retry_stall", {31'd0, Stall}, 32'd1);
        tick();
        chk("to_retry_req", {31'd0, Mem_Req}, 32'd1);
        Mem_Ack = 1'b1; Mem_RData = 32'hA5A5A5A5;
        #1;
        chk("to_ack_stall", {31'd0, Stall}, 32'd0);
        tick();
        Mem_Ack = 1'b0;
        chk("to_rdata", ReadData_OUT, 32'hA5A5A5A5);
        chk("to_wb", {30'd0, WB_OUT}, 32'd3);
        chk("to_err_sticky", {31'd0, Bus_Err}, 32'd1);
        chk("mis_sticky", {31'd0, Misalign}, 32'd1);

        // stray ack in IDLE is ignored
        drive(2'b01, 3'b000, 32'h99, 32'd0, 5'd9, 1'b0, 32'd0);
        Mem_Ack = 1'b1; Mem_RData = 32'h55;
        tick();
        Mem_Ack = 1'b0;
        chk("idle_ack_req", {31'd0, Mem_Req}, 32'd0);
        chk("idle_ack_rd", ReadData_OUT, 32'd0);
        chk("idle_ack_wb", {30'd0, WB_OUT}, 32'd1);

        // async reset mid-ACCESS
        drive(2'b11, 3'b010, 32'h80, 32'd0, 5'd1, 1'b0, 32'd0);
        tick();
        chk("mid_req_before", {31'd0, Mem_Req}, 32'd1);
        #2 Rst_n = 1'b0;
        #1;
        chk("mid_req", {31'd0, Mem_Req}, 32'd0);
        chk("mid_wb", {30'd0, WB_OUT}, 32'd0);
        chk("mid_stall", {31'd0, Stall}, 32'd0);
        chk("mid_flags", {30'd0, Misalign, Bus_Err}, 32'd0);
        drive(2'b00, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        tick();
        Rst_n = 1'b1;
        #1;
        chk("post_rst_stall", {31'd0, Stall}, 32'd0);
        tick();
        chk("post_rst_req", {31'd0, Mem_Req}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
